game_turn_ctrl: RTL
===================

// Module: game_turn_ctrl
// PURPOSE
// - Sequences the battleship game over the two ship boards: clear, host placement, guest placement, alternating shots, game over.
// - Single owner of the board access port: turns player clicks into read-modify-write transactions on the board.
// - Produces turn, hit counts and winner for the display and UART layers.
// PARAMETERS
// - SHIP_CELLS      10    ship cells each player places; also the hit count that wins the game (max 15)
// - BOARD_DIM       10    board rows/cols; coordinates >= BOARD_DIM are rejected
// - TIMEOUT_CYCLES  65e6  turn timeout in clk cycles (used only with GAME_TURN_TIMEOUT_EN)
// PORTS
// - clk          in   1  system clock
// - rst_n        in   1  asynchronous, active-low reset
// - start        in   1  1-cycle pulse; starts the game from IDLE or OVER
// - host_click   in   1  1-cycle pulse, host selects cell host_pos
// - host_pos     in   8  {row[7:4], col[3:0]}
// - guest_click  in   1  1-cycle pulse, guest selects cell guest_pos
// - guest_pos    in   8  {row[7:4], col[3:0]}
// - brd_clr      out  1  1-cycle pulse; board clears both boards
// - brd_req      out  1  board access request, held until brd_ack
// - brd_wr       out  1  1 = write brd_wcode, 0 = read
// - brd_side     out  1  board addressed: 0 = host, 1 = guest
// - brd_row      out  4  cell row
// - brd_col      out  4  cell column
// - brd_wcode    out  2  code to write
// - brd_ack      in   1  board done; brd_rcode valid in the same cycle for a read
// - brd_rcode    in   2  cell code: 00 empty, 01 ship, 10 hit, 11 miss
// - phase        out  2  00 IDLE, 01 PLACE, 10 BATTLE, 11 OVER
// - turn         out  1  active player: 0 = host, 1 = guest
// - hits_host    out  4  hits scored by host on guest board
// - hits_guest   out  4  hits scored by guest on host board
// - shot_valid   out  1  1-cycle pulse; a shot was resolved
// - shot_hit     out  1  result of the last shot, valid with shot_valid
// - winner       out  1  0 = host, 1 = guest; valid while phase = OVER
// BEHAVIOUR
// - Reset (async, any state, mid-transaction included): state IDLE; all outputs 0; brd_req drops immediately.
// - FSM states: IDLE, CLEAR, P_WAIT, P_RD, P_WR, S_WAIT, S_RD, S_WR, OVER.
// - IDLE/OVER + start -> CLEAR: brd_clr = 1 for one cycle; counters, turn and winner cleared -> P_WAIT with turn = 0.
// - Click acceptance: only in P_WAIT/S_WAIT, only the click of the active player; other clicks, clicks in other states and clicks with row or col >= BOARD_DIM are dropped. Nothing is queued.
// - Both clicks in the same cycle: the active player's click is taken; the other is dropped.
// - Board handshake: brd_req is registered, asserted the cycle after the triggering event, with wr/side/row/col/wcode stable until brd_ack is sampled high. Back-to-back: a follow-up write is asserted the cycle after the read ack.
// - Placement: P_WAIT click -> P_RD reads the player's own board. Code 00 -> P_WR writes 01, count++; any other code -> P_WAIT, no count change.
// - At count == SHIP_CELLS: host -> count = 0, turn = 1, P_WAIT. Guest -> turn = 0, S_WAIT (phase BATTLE).
// - Shot: S_WAIT click -> S_RD reads the opponent board. 10/11 -> already shot, back to S_WAIT with the same turn and no pulse.
// - Shot on 01 -> S_WR writes 10. On ack: shooter's hits++, shot_valid = 1, shot_hit = 1, turn kept.
// - Shot on 00 -> S_WR writes 11. On ack: shot_valid = 1, shot_hit = 0, turn toggles.
// - Win: a hit that brings the shooter's hits to SHIP_CELLS -> OVER, winner = shooter. Hit counters saturate and never wrap.
// - Latency: click to brd_req takes 1 cycle. brd_ack of the write to shot_valid/next state takes 1 cycle.
// CONFIGURATION
// - GAME_TURN_TIMEOUT_EN defined: counter runs in P_WAIT/S_WAIT and resets on every accepted click.
//   - Reaching TIMEOUT_CYCLES in S_WAIT toggles turn with no board access.
//   - Reaching it in P_WAIT restarts the counter only.
// - Not defined: no timer logic; waits are unbounded.
// TESTING
// - rst_n low during S_RD with brd_req = 1 -> brd_req = 0 at once; phase = 00; hits = 0.
// - start, then host clicks 0x00..0x09 with the board model acking reads of 00 -> 10 writes of 01; turn = 1 after the 10th ack.
// - Host clicks 0x23 twice (rcode 01 on the 2nd read) -> count increments once; 2nd click issues a read only. Click 0xA0 -> no brd_req.
// - BATTLE, host shoots 0x45 (rcode 01) -> write 10 to side 1; shot_hit = 1; hits_host = 1; turn = 0.
// - Host shoots 0x46 (rcode 00) -> write 11, turn = 1. Guest shoots an already-11 cell -> no write, no pulse, turn = 1.
// - Host reaches 10 hits -> phase = 11, winner = 0. Clicks ignored. start -> brd_clr pulse, phase = 01.

Source files
------------

// File: rtl/game_turn_ctrl.sv
// game_turn_ctrl: battleship game sequencer and sole owner of the board port.
// Optional turn timeout: define GAME_TURN_TIMEOUT_EN.
module game_turn_ctrl #(
    parameter int SHIP_CELLS     = 10,
    parameter int BOARD_DIM      = 10,
    parameter int TIMEOUT_CYCLES = 65_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       host_click,
    input  logic [7:0] host_pos,
    input  logic       guest_click,
    input  logic [7:0] guest_pos,
    output logic       brd_clr,
    output logic       brd_req,
    output logic       brd_wr,
    output logic       brd_side,
    output logic [3:0] brd_row,
    output logic [3:0] brd_col,
    output logic [1:0] brd_wcode,
    input  logic       brd_ack,
    input  logic [1:0] brd_rcode,
    output logic [1:0] phase,
    output logic       turn,
    output logic [3:0] hits_host,
    output logic [3:0] hits_guest,
    output logic       shot_valid,
    output logic       shot_hit,
    output logic       winner
);

    typedef enum logic [3:0] {
        IDLE,
        CLEAR,
        P_WAIT,
        P_RD,
        P_WR,
        S_WAIT,
        S_RD,
        S_WR,
        OVER
    } state_t;

    localparam logic [1:0] CODE_EMPTY = 2'b00;
    localparam logic [1:0] CODE_SHIP  = 2'b01;
    localparam logic [1:0] CODE_HIT   = 2'b10;
    localparam logic [1:0] CODE_MISS  = 2'b11;

    localparam logic [4:0] DIM   = 5'(BOARD_DIM);
    localparam logic [3:0] SHIPS = 4'(SHIP_CELLS);

    if (SHIP_CELLS < 1 || SHIP_CELLS > 15) begin : g_bad_ships
        $error("SHIP_CELLS must be in 1..15");
    end
    if (BOARD_DIM < 1 || BOARD_DIM > 16) begin : g_bad_dim
        $error("BOARD_DIM must be in 1..16");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_tmo
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    state_t     state;
    logic [3:0] place_cnt;
    logic       shot_is_hit;

    logic       host_ok;
    logic       guest_ok;
    logic       act_click;
    logic [7:0] act_pos;
    logic       in_wait;
    logic       accept;
    logic       tmo_fire;
    logic [3:0] hits_cur;
    logic [3:0] hits_inc;

    // Out-of-range cells never reach the board.
    assign host_ok = host_click
                  && ({1'b0, host_pos[7:4]} < DIM)
                  && ({1'b0, host_pos[3:0]} < DIM);
    assign guest_ok = guest_click
                   && ({1'b0, guest_pos[7:4]} < DIM)
                   && ({1'b0, guest_pos[3:0]} < DIM);

    // Only the active player's click is seen; the other one is dropped.
    assign act_click = turn ? guest_ok : host_ok;
    assign act_pos   = turn ? guest_pos : host_pos;
    assign in_wait   = (state == P_WAIT) || (state == S_WAIT);
    assign accept    = in_wait && act_click;

    // Shooter's hit count after one more hit, saturating at all ones.
    assign hits_cur = turn ? hits_guest : hits_host;
    assign hits_inc = (hits_cur == 4'hF) ? hits_cur : hits_cur + 4'd1;

`ifdef GAME_TURN_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    logic [TMO_W-1:0] tmo_cnt;

    assign tmo_fire = in_wait && !accept && (tmo_cnt == TMO_LAST);

    // Idle-turn timer: runs only while waiting for a click.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
        end else if (!in_wait || accept || tmo_fire) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end
`else
    assign tmo_fire = 1'b0;
`endif

    // Game sequencer with registered board handshake and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            place_cnt   <= 4'd0;
            shot_is_hit <= 1'b0;
            brd_clr     <= 1'b0;
            brd_req     <= 1'b0;
            brd_wr      <= 1'b0;
            brd_side    <= 1'b0;
            brd_row     <= 4'd0;
            brd_col     <= 4'd0;
            brd_wcode   <= 2'b00;
            turn        <= 1'b0;
            hits_host   <= 4'd0;
            hits_guest  <= 4'd0;
            shot_valid  <= 1'b0;
            shot_hit    <= 1'b0;
            winner      <= 1'b0;
        end else begin
            brd_clr    <= 1'b0;
            shot_valid <= 1'b0;
            unique case (state)
                IDLE, OVER: begin
                    if (start) begin
                        state      <= CLEAR;
                        brd_clr    <= 1'b1;
                        place_cnt  <= 4'd0;
                        turn       <= 1'b0;
                        winner     <= 1'b0;
                        hits_host  <= 4'd0;
                        hits_guest <= 4'd0;
                        shot_hit   <= 1'b0;
                    end
                end
                CLEAR: begin
                    state <= P_WAIT;
                end
                P_WAIT: begin
                    if (accept) begin
                        brd_req   <= 1'b1;
                        brd_wr    <= 1'b0;
                        brd_side  <= turn;
                        brd_row   <= act_pos[7:4];
                        brd_col   <= act_pos[3:0];
                        brd_wcode <= CODE_EMPTY;
                        state     <= P_RD;
                    end
                end
                P_RD: begin
                    if (brd_ack) begin
                        if (brd_rcode == CODE_EMPTY) begin
                            brd_wr    <= 1'b1;
                            brd_wcode <= CODE_SHIP;
                            state     <= P_WR;
                        end else begin
                            brd_req <= 1'b0;
                            state   <= P_WAIT;
                        end
                    end
                end
                P_WR: begin
                    if (brd_ack) begin
                        brd_req <= 1'b0;
                        brd_wr  <= 1'b0;
                        if (place_cnt + 4'd1 == SHIPS) begin
                            place_cnt <= 4'd0;
                            turn      <= ~turn;
                            state     <= turn ? S_WAIT : P_WAIT;
                        end else begin
                            place_cnt <= place_cnt + 4'd1;
                            state     <= P_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (accept) begin
                        brd_req   <= 1'b1;
                        brd_wr    <= 1'b0;
                        brd_side  <= ~turn;
                        brd_row   <= act_pos[7:4];
                        brd_col   <= act_pos[3:0];
                        brd_wcode <= CODE_EMPTY;
                        state     <= S_RD;
                    end else if (tmo_fire) begin
                        turn <= ~turn;
                    end
                end
                S_RD: begin
                    if (brd_ack) begin
                        case (brd_rcode)
                            CODE_SHIP: begin
                                brd_wr      <= 1'b1;
                                brd_wcode   <= CODE_HIT;
                                shot_is_hit <= 1'b1;
                                state       <= S_WR;
                            end
                            CODE_EMPTY: begin
                                brd_wr      <= 1'b1;
                                brd_wcode   <= CODE_MISS;
                                shot_is_hit <= 1'b0;
                                state       <= S_WR;
                            end
                            default: begin
                                brd_req <= 1'b0;
                                state   <= S_WAIT;
                            end
                        endcase
                    end
                end
                S_WR: begin
                    if (brd_ack) begin
                        brd_req    <= 1'b0;
                        brd_wr     <= 1'b0;
                        shot_valid <= 1'b1;
                        shot_hit   <= shot_is_hit;
                        if (shot_is_hit) begin
                            if (turn) begin
                                hits_guest <= hits_inc;
                            end else begin
                                hits_host <= hits_inc;
                            end
                            if (hits_inc == SHIPS) begin
                                winner <= turn;
                                state  <= OVER;
                            end else begin
                                state <= S_WAIT;
                            end
                        end else begin
                            turn  <= ~turn;
                            state <= S_WAIT;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Phase is a pure decode of the state register.
    always_comb begin
        phase = 2'b00;
        unique case (state)
            IDLE:                     phase = 2'b00;
            CLEAR, P_WAIT, P_RD, P_WR: phase = 2'b01;
            S_WAIT, S_RD, S_WR:       phase = 2'b10;
            OVER:                     phase = 2'b11;
            default:                  phase = 2'b00;
        endcase
    end

endmodule
